// File: rtl/layer_mac_sequencer_if.sv
// Handshake bundle between the layer controller / MAC side and the sequencer.
// The sequencer takes the slave view; the controller/MAC side takes the master view.
interface layer_mac_sequencer_if #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 1
);
    logic             start;
    logic             ack;
    logic             req;
    logic [IN_W-1:0]  in_idx;
    logic [OUT_W-1:0] out_idx;
    logic             clr_acc;
    logic             ack_mac;
    logic             busy;
    logic             done;

    modport master (
        output start, ack,
        input  req, in_idx, out_idx, clr_acc, ack_mac, busy, done
    );

    modport slave (
        input  start, ack,
        output req, in_idx, out_idx, clr_acc, ack_mac, busy, done
    );
endinterface

// File: rtl/layer_mac_sequencer.sv
// Walks every neuron of a layer, issuing one MAC request per element with stable indices.
// State advances on the falling clock edge to line up with the rest of the network datapath.
module layer_mac_sequencer #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int IN_W  = 2,
    parameter int OUT_W = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    layer_mac_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_FLAG,
        S_DONE
    } state_t;

    localparam logic [IN_W-1:0]  LAST_IN  = IN_W'(N_IN - 1);
    localparam logic [OUT_W-1:0] LAST_OUT = OUT_W'(N_OUT - 1);

    state_t           r_state;
    logic             r_req;
    logic [IN_W-1:0]  r_in_idx;
    logic [OUT_W-1:0] r_out_idx;
    logic             r_clr_acc;
    logic             r_ack_mac;
    logic             r_busy;
    logic             r_done;

    state_t           w_state;
    logic             w_req;
    logic [IN_W-1:0]  w_in_idx;
    logic [OUT_W-1:0] w_out_idx;
    logic             w_clr_acc;
    logic             w_ack_mac;
    logic             w_busy;
    logic             w_done;

    always_ff @(negedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_in_idx  <= '0;
            r_out_idx <= '0;
            r_clr_acc <= 1'b0;
            r_ack_mac <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_req     <= w_req;
            r_in_idx  <= w_in_idx;
            r_out_idx <= w_out_idx;
            r_clr_acc <= w_clr_acc;
            r_ack_mac <= w_ack_mac;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    // Pulses (clr_acc, ack_mac) default low; everything else holds unless a transition says otherwise.
    always_comb begin
        w_state   = r_state;
        w_req     = r_req;
        w_in_idx  = r_in_idx;
        w_out_idx = r_out_idx;
        w_clr_acc = 1'b0;
        w_ack_mac = 1'b0;
        w_busy    = r_busy;
        w_done    = r_done;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state   = S_CLEAR;
                    w_clr_acc = 1'b1;
                    w_in_idx  = '0;
                    w_out_idx = '0;
                    w_busy    = 1'b1;
                    w_done    = 1'b0;
                end
            end
            S_CLEAR: begin
                w_state = S_ISSUE;
                w_req   = 1'b1;
            end
            S_ISSUE: begin
                if (bus.ack && r_req) begin
                    if (r_in_idx == LAST_IN) begin
                        w_state   = S_FLAG;
                        w_req     = 1'b0;
                        w_ack_mac = 1'b1;
                    end else begin
                        w_in_idx = r_in_idx + IN_W'(1);
                    end
                end
            end
            S_FLAG: begin
                if (r_out_idx == LAST_OUT) begin
                    w_state = S_DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_state   = S_CLEAR;
                    w_out_idx = r_out_idx + OUT_W'(1);
                    w_in_idx  = '0;
                    w_clr_acc = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.req     = r_req;
    assign bus.in_idx  = r_in_idx;
    assign bus.out_idx = r_out_idx;
    assign bus.clr_acc = r_clr_acc;
    assign bus.ack_mac = r_ack_mac;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Directed bench for layer_mac_sequencer (N_IN=3, N_OUT=2) with hand-computed per-edge output vectors.
module tb_layer_mac_sequencer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    layer_mac_sequencer_if #(.IN_W(2), .OUT_W(1)) bus ();

    layer_mac_sequencer #(
        .N_IN (3),
        .N_OUT(2),
        .IN_W (2),
        .OUT_W(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed view: {req, in_idx[1:0], out_idx, clr_acc, ack_mac, busy, done}
    logic [7:0] exp_tab [11] = '{
        8'b0000_1010,  // e0  CLEAR n0
        8'b1000_0010,  // e1  req, in0
        8'b1010_0010,  // e2  in1
        8'b1100_0010,  // e3  in2
        8'b0100_0110,  // e4  ack_mac n0
        8'b0001_1010,  // e5  CLEAR n1
        8'b1001_0010,  // e6
        8'b1011_0010,  // e7
        8'b1101_0010,  // e8
        8'b0101_0110,  // e9  ack_mac n1
        8'b0101_0001   // e10 DONE
    };

    function automatic logic [7:0] obs();
        return {bus.req, bus.in_idx, bus.out_idx, bus.clr_acc, bus.ack_mac, bus.busy, bus.done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Pass one falling (active) edge and land at the next rising edge to sample and drive.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input string name, input bit hold_start, input int abort_at);
        for (int k = 0; k <= 10; k++) begin
            bus.start = (k == 0) || hold_start;
            rst       = (k == abort_at);
            tick();
            if (k == abort_at) begin
                chk($sformatf("%s rst e%0d", name, k), {24'd0, obs()}, 32'd0);
                rst       = 1'b0;
                bus.start = 1'b0;
                return;
            end
            chk($sformatf("%s e%0d", name, k), {24'd0, obs()}, {24'd0, exp_tab[k]});
        end
        bus.start = 1'b0;
    endtask

    initial begin
        logic [2:0] acc_pair [6];
        logic [2:0] exp_pair [6] = '{3'b000, 3'b010, 3'b100, 3'b001, 3'b011, 3'b101};
        int         acc, pulses, rises, viol;
        logic       p_req, p_ack, p_done, p_out;
        logic [1:0] p_in;
        bit         fin;

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.ack   = 1'b1;
        #1;

        // Scenario 1: reset, then idle with ack high and no start
        tick();
        tick();
        chk("reset outs", {24'd0, obs()}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("idle e%0d", k), {24'd0, obs()}, 32'd0);
        end

        // Scenario 2: zero-wait pass, then DONE holds with ack still high
        run_pass("zw", 1'b0, -1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("done hold %0d", k), {24'd0, obs()}, {24'd0, exp_tab[10]});
        end

        // Scenario 6 + 4: restart from DONE while start stays high through the busy pass
        run_pass("busy start", 1'b1, -1);
        tick();
        chk("after busy start", {24'd0, obs()}, {24'd0, exp_tab[10]});

        // Scenario 5: reset at e7, then a fresh pass from IDLE
        run_pass("abort", 1'b0, 7);
        tick();
        chk("post abort idle", {24'd0, obs()}, 32'd0);
        run_pass("after abort", 1'b0, -1);

        // Scenario 3: acks only every third cycle
        bus.ack   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("stall clr", {31'd0, bus.clr_acc}, 32'd1);
        acc    = 0;
        pulses = 0;
        rises  = 0;
        viol   = 0;
        fin    = 1'b0;
        p_done = bus.done;
        for (int k = 0; k < 90 && !fin; k++) begin
            bus.ack = (k % 3 == 2);
            if (bus.req && bus.ack) begin
                if (acc < 6) acc_pair[acc] = {bus.in_idx, bus.out_idx};
                acc++;
            end
            p_req = bus.req;
            p_ack = bus.ack;
            p_in  = bus.in_idx;
            p_out = bus.out_idx;
            tick();
            if (p_req && !p_ack && (bus.req !== 1'b1 || bus.in_idx !== p_in || bus.out_idx !== p_out))
                viol++;
            if (int'(bus.req) + int'(bus.clr_acc) + int'(bus.ack_mac) > 1)
                viol++;
            if (bus.ack_mac) pulses++;
            if (bus.done && !p_done) rises++;
            p_done = bus.done;
            if (bus.done) fin = 1'b1;
        end
        bus.ack = 1'b1;
        chk("stall done", {31'd0, bus.done}, 32'd1);
        chk("stall viol", viol, 32'd0);
        chk("stall accepted", acc, 32'd6);
        chk("stall ack_mac", pulses, 32'd2);
        chk("stall done rises", rises, 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < acc)
                chk($sformatf("stall elem%0d", i), {29'd0, acc_pair[i]}, {29'd0, exp_pair[i]});
            else
                chk($sformatf("stall elem%0d", i), 32'hffff_ffff, {29'd0, exp_pair[i]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
